// File: rtl/video_fetch_buf_pkg.sv
// Shared definitions for the video fetch buffer.
// Contents:
//   vfb_state_t    : FSM state encoding (IDLE, FETCH, FULL, DRAIN)
//   VFB_WORD_W     : DRAM word width
//   VFB_CNT_W      : counter width for the default burst length
//   vfb_cnt_w()    : counter width for a given burst length, $clog2(n+1)
package video_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } vfb_state_t;

  localparam int VFB_WORD_W         = 16;
  localparam int VFB_NWORDS_DEFAULT = 4;
  localparam int VFB_CNT_W          = $clog2(VFB_NWORDS_DEFAULT + 1);

  // A counter must hold 0..nwords inclusive.
  function automatic int vfb_cnt_w(input int nwords);
    return $clog2(nwords + 1);
  endfunction

endpackage

// File: rtl/video_fetch_buf_if.sv
// Bus bundle between the DRAM arbiter / window timing (master side) and
// the fetch buffer (slave side).
// Signals:
//   fetch_start, fetch_end        : window open / close pulses
//   video_next                    : arbiter accepted one video address
//   video_strobe, video_data      : DRAM read word, valid when strobe is high
//   video_go                      : request enable to the arbiter
//   pic_bits, pic_valid           : burst output, valid pulse
//   underrun, collision           : sticky error flags
//   state                         : FSM state for observation
// Handshake: video_data is taken on any rising edge where video_strobe is
// high and the buffer is in FETCH; there is no back-pressure. video_next is
// counted only while video_go is high. pic_bits is valid on the cycle
// pic_valid is high and holds until the next pulse.
interface video_fetch_buf_if #(parameter int NWORDS = 4);
  import video_pkg::*;

  logic                         fetch_start;
  logic                         fetch_end;
  logic                         video_next;
  logic                         video_strobe;
  logic [VFB_WORD_W-1:0]        video_data;
  logic                         video_go;
  logic [VFB_WORD_W*NWORDS-1:0] pic_bits;
  logic                         pic_valid;
  logic                         underrun;
  logic                         collision;
  vfb_state_t                   state;

  modport master (
    output fetch_start, fetch_end, video_next, video_strobe, video_data,
    input  video_go, pic_bits, pic_valid, underrun, collision, state
  );

  modport slave (
    input  fetch_start, fetch_end, video_next, video_strobe, video_data,
    output video_go, pic_bits, pic_valid, underrun, collision, state
  );

endinterface

// File: rtl/video_fetch_ctr.sv
// Saturating up/down counter used for request, data and drain counts.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear (highest priority after rst)
//   load       : load load_val
//   inc, dec   : step up (saturates at MAX) / down (saturates at 0);
//                both together leave the count unchanged
//   cnt        : current count
module video_fetch_ctr #(
  parameter int W   = 3,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && !dec && cnt != MAX_C) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/video_fetch_buf.sv
// Video fetch burst buffer. Collects NWORDS DRAM words per fetch window,
// hands the burst to the renderer as one wide word on fetch_end, and gates
// the arbiter request enable so one burst at most is outstanding.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : video_fetch_buf_if slave modport (see interface header)
module video_fetch_buf
  import video_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  video_fetch_buf_if.slave  bus
);

  localparam int CW = vfb_cnt_w(NWORDS);
  localparam int IW = $clog2(NWORDS);
  localparam logic [CW-1:0] N_C = CW'(NWORDS);

  vfb_state_t state, state_nxt;

  logic [VFB_WORD_W-1:0]        buf_q    [NWORDS];
  logic [VFB_WORD_W-1:0]        buf_nxt  [NWORDS];
  logic [VFB_WORD_W*NWORDS-1:0] buf_flat;
  logic [VFB_WORD_W*NWORDS-1:0] pic_q;
  logic pic_valid_q, underrun_q, collision_q;

  logic [CW-1:0] req_cnt, dat_cnt, pend;
  logic [CW-1:0] req_after, dat_after, pend_val;
  logic store, req_inc, complete;
  logic pic_load, set_underrun, set_collision, take_start;
  logic pend_load, pend_dec;

  video_fetch_ctr #(.W(CW), .MAX(NWORDS)) u_req (
    .clk(clk), .rst(rst), .clr(take_start), .load(1'b0), .load_val('0),
    .inc(req_inc), .dec(1'b0), .cnt(req_cnt)
  );

  video_fetch_ctr #(.W(CW), .MAX(NWORDS)) u_dat (
    .clk(clk), .rst(rst), .clr(take_start), .load(1'b0), .load_val('0),
    .inc(store), .dec(1'b0), .cnt(dat_cnt)
  );

  video_fetch_ctr #(.W(CW), .MAX(NWORDS)) u_pend (
    .clk(clk), .rst(rst), .clr(1'b0), .load(pend_load), .load_val(pend_val),
    .inc(1'b0), .dec(pend_dec), .cnt(pend)
  );

  // Buffer contents including this cycle's strobe, so a word arriving with
  // fetch_end still lands in pic_bits.
  always_comb begin
    buf_nxt = buf_q;
    if (store) buf_nxt[dat_cnt[IW-1:0]] = bus.video_data;
    buf_flat = '0;
    for (int i = 0; i < NWORDS; i++) begin
      buf_flat[i*VFB_WORD_W +: VFB_WORD_W] = buf_nxt[i];
    end
  end

  always_comb begin
    store     = (state == FETCH) && bus.video_strobe;
    req_inc   = (state == FETCH) && bus.video_next;
    dat_after = dat_cnt + CW'(store);
    req_after = req_cnt + CW'(req_inc && req_cnt != N_C);
    complete  = store && (dat_after == N_C);
    // Outstanding requests whose data has not yet arrived.
    pend_val  = (req_after > dat_after) ? (req_after - dat_after) : '0;

    state_nxt    = state;
    pic_load     = 1'b0;
    set_underrun = 1'b0;
    pend_load    = 1'b0;
    pend_dec     = 1'b0;

    case (state)
      IDLE: ;
      FETCH: begin
        if (bus.fetch_end) begin
          pic_load = 1'b1;
          if (complete) begin
            state_nxt = IDLE;
          end else begin
            set_underrun = 1'b1;
            pend_load    = 1'b1;
            state_nxt    = (pend_val != '0) ? DRAIN : IDLE;
          end
        end else if (complete) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (bus.fetch_end) begin
          pic_load  = 1'b1;
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (bus.video_strobe) begin
          pend_dec = 1'b1;
          if (pend == CW'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A new window may open only from IDLE or from a window closed this cycle
    // straight back to IDLE; anything else is a collision.
    take_start    = bus.fetch_start &&
                    ((state == IDLE) || (pic_load && state_nxt == IDLE));
    set_collision = bus.fetch_start && !take_start;
    if (take_start) state_nxt = FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pic_q       <= '0;
      pic_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      collision_q <= 1'b0;
      for (int i = 0; i < NWORDS; i++) buf_q[i] <= '0;
    end else begin
      state       <= state_nxt;
      buf_q       <= buf_nxt;
      pic_valid_q <= pic_load;
      if (pic_load)      pic_q       <= buf_flat;
      if (set_underrun)  underrun_q  <= 1'b1;
      if (set_collision) collision_q <= 1'b1;
    end
  end

  assign bus.video_go  = (state == FETCH) && (req_cnt != N_C);
  assign bus.pic_bits  = pic_q;
  assign bus.pic_valid = pic_valid_q;
  assign bus.underrun  = underrun_q;
  assign bus.collision = collision_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_video_fetch_buf.sv
// Testbench for video_fetch_buf (NWORDS=4): directed vectors, a window-level
// behavioural model compared every cycle, and literal expectations.
module tb_video_fetch_buf;
  import video_pkg::*;

  localparam int N = 4;
  localparam int PW = 16 * N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_fetch_buf_if #(.NWORDS(N)) bus ();

  video_fetch_buf #(.NWORDS(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int go_cnt   = 0;
  bit started  = 0;

  task automatic check(input string name, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Window-level view: an open window with a list of received words and a
  // count of accepted requests, or a number of late strobes still owed.
  bit              m_open  = 0;
  int              m_nw    = 0;
  int              m_reqs  = 0;
  int              m_drain = 0;
  logic [15:0]     m_buf [N];
  logic [PW-1:0]   m_pic   = '0;
  bit              m_pv    = 0;
  bit              m_und   = 0;
  bit              m_col   = 0;

  initial for (int i = 0; i < N; i++) m_buf[i] = '0;

  function automatic logic [PW-1:0] pack_buf();
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*16 +: 16] = m_buf[i];
    return r;
  endfunction

  always @(posedge clk) begin
    bit idle_before;
    bit ended;
    bit fetching;
    started = 1;
    if (rst) begin
      m_open = 0; m_nw = 0; m_reqs = 0; m_drain = 0;
      m_pic = '0; m_pv = 0; m_und = 0; m_col = 0;
      for (int i = 0; i < N; i++) m_buf[i] = '0;
    end else begin
      m_pv        = 0;
      idle_before = !m_open && (m_drain == 0);
      ended       = 0;
      if (m_open) begin
        fetching = (m_nw < N);
        if (fetching && bus.video_next && m_reqs < N) m_reqs++;
        if (fetching && bus.video_strobe) begin
          m_buf[m_nw] = bus.video_data;
          m_nw++;
        end
        if (bus.fetch_end) begin
          m_pic = pack_buf();
          m_pv  = 1;
          if (m_nw < N) begin
            m_und   = 1;
            m_drain = (m_reqs > m_nw) ? (m_reqs - m_nw) : 0;
          end
          m_open = 0;
          ended  = 1;
        end
      end else if (m_drain > 0 && bus.video_strobe) begin
        m_drain--;
      end
      if (bus.fetch_start) begin
        if (idle_before || (ended && m_drain == 0)) begin
          m_open = 1; m_reqs = 0; m_nw = 0;
        end else begin
          m_col = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      check("video_go",  PW'(bus.video_go),  PW'(m_open && m_nw < N && m_reqs < N));
      check("pic_bits",  bus.pic_bits,       m_pic);
      check("pic_valid", PW'(bus.pic_valid), PW'(m_pv));
      check("underrun",  PW'(bus.underrun),  PW'(m_und));
      check("collision", PW'(bus.collision), PW'(m_col));
      check("idle",      PW'(bus.state == IDLE), PW'(!m_open && m_drain == 0));
      if (bus.video_go) go_cnt++;
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic fs, input logic fe, input logic nx,
                      input logic st, input logic [15:0] d);
    bus.fetch_start  = fs;
    bus.fetch_end    = fe;
    bus.video_next   = nx;
    bus.video_strobe = st;
    bus.video_data   = d;
    @(posedge clk);
    #2;
    bus.fetch_start  = 1'b0;
    bus.fetch_end    = 1'b0;
    bus.video_next   = 1'b0;
    bus.video_strobe = 1'b0;
    bus.video_data   = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 16'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.fetch_start = 0; bus.fetch_end = 0; bus.video_next = 0;
    bus.video_strobe = 0; bus.video_data = '0;

    rst = 1'b1;
    idle(3);
    check("rst_pic",  bus.pic_bits, '0);
    check("rst_go",   PW'(bus.video_go), '0);
    check("rst_und",  PW'(bus.underrun), '0);
    check("rst_col",  PW'(bus.collision), '0);
    rst = 1'b0;
    idle(2);

    // Normal burst
    go_cnt = 0;
    step(1, 0, 0, 0, 16'h0);
    step(0, 0, 1, 0, 16'h0);
    step(0, 0, 1, 0, 16'h0);
    step(0, 0, 1, 1, 16'h1111);
    step(0, 0, 1, 1, 16'h2222);
    step(0, 0, 0, 1, 16'h3333);
    step(0, 0, 0, 1, 16'h4444);
    step(0, 1, 0, 0, 16'h0);
    check("t1_pic", bus.pic_bits, 64'h4444_3333_2222_1111);
    check("t1_pv",  PW'(bus.pic_valid), PW'(1));
    check("t1_und", PW'(bus.underrun), '0);
    check("t1_go_cycles", PW'(go_cnt), PW'(4));
    idle(2);
    check("t1_pv_one_cycle", PW'(bus.pic_valid), '0);

    // Same-cycle completion
    step(1, 0, 0, 0, 16'h0);
    step(0, 0, 1, 0, 16'h0);
    step(0, 0, 1, 1, 16'h9991);
    step(0, 0, 1, 1, 16'h9992);
    step(0, 0, 1, 1, 16'h9993);
    step(0, 1, 0, 1, 16'hAAAA);
    check("t3_pic", bus.pic_bits, 64'hAAAA_9993_9992_9991);
    check("t3_und", PW'(bus.underrun), '0);
    idle(2);

    // Back-to-back windows: fetch_end in FULL with fetch_start
    step(1, 0, 0, 0, 16'h0);
    step(0, 0, 1, 0, 16'h0);
    step(0, 0, 1, 1, 16'hC001);
    step(0, 0, 1, 1, 16'hC002);
    step(0, 0, 1, 1, 16'hC003);
    step(0, 0, 0, 1, 16'hC004);
    step(1, 1, 0, 0, 16'h0);
    check("t4_pv",  PW'(bus.pic_valid), PW'(1));
    check("t4_pic", bus.pic_bits, 64'hC004_C003_C002_C001);
    check("t4_go",  PW'(bus.video_go), PW'(1));
    check("t4_col", PW'(bus.collision), '0);

    // Early close in the second window, then collision during DRAIN
    step(0, 0, 1, 0, 16'h0);
    step(0, 0, 1, 0, 16'h0);
    step(0, 0, 1, 1, 16'h5555);
    step(0, 0, 1, 1, 16'h6666);
    step(0, 1, 0, 0, 16'h0);
    check("t2_und", PW'(bus.underrun), PW'(1));
    check("t2_pic", bus.pic_bits, 64'hC004_C003_6666_5555);
    check("t2_drain", PW'(bus.state == IDLE), '0);
    go_cnt = 0;
    step(1, 0, 0, 1, 16'h7777);
    check("t5_col", PW'(bus.collision), PW'(1));
    step(0, 0, 0, 1, 16'h8888);
    check("t2_idle", PW'(bus.state == IDLE), PW'(1));
    check("t2_pic_hold", bus.pic_bits, 64'hC004_C003_6666_5555);
    idle(2);
    check("t5_go_cycles", PW'(go_cnt), '0);

    // Reset mid-window
    step(1, 0, 0, 0, 16'h0);
    step(0, 0, 1, 1, 16'hD001);
    step(0, 0, 1, 1, 16'hD002);
    rst = 1'b1;
    step(0, 0, 0, 0, 16'h0);
    rst = 1'b0;
    step(0, 0, 0, 1, 16'hE001);
    step(0, 0, 0, 1, 16'hE002);
    check("t6_pic", bus.pic_bits, '0);
    check("t6_und", PW'(bus.underrun), '0);
    check("t6_col", PW'(bus.collision), '0);
    check("t6_go",  PW'(bus.video_go), '0);
    // Empty window exposes the buffer: nothing may have been written.
    step(1, 0, 0, 0, 16'h0);
    step(0, 1, 0, 0, 16'h0);
    check("t6_buf", bus.pic_bits, '0);
    check("t6_pv",  PW'(bus.pic_valid), PW'(1));
    check("t6_und_close", PW'(bus.underrun), PW'(1));
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
